// File: rtl/temp_monitor_mc_if.sv
// Sample/result bundle for temp_monitor_mc: the sample side is driven by the master,
// and results plus alarm levels are driven by the slave.
interface temp_monitor_mc_if #(
    parameter int CHANNELS = 4,
    parameter int DIGITS   = 3
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                        en;
    logic                        mode;
    logic                        in_valid;
    logic [CH_W-1:0]             in_ch;
    logic [DIGITS*4-1:0]         in_bcd;
    logic                        in_sign;
    logic                        out_valid;
    logic [CH_W-1:0]             out_ch;
    logic [(DIGITS+1)*4-1:0]     out_delta_bcd;
    logic                        out_delta_sign;
    logic [2:0]                  out_state;
    logic                        out_err;
    logic [CHANNELS-1:0]         alarm;

    modport master (
        output en, mode, in_valid, in_ch, in_bcd, in_sign,
        input  out_valid, out_ch, out_delta_bcd, out_delta_sign, out_state, out_err, alarm
    );

    modport slave (
        input  en, mode, in_valid, in_ch, in_bcd, in_sign,
        output out_valid, out_ch, out_delta_bcd, out_delta_sign, out_state, out_err, alarm
    );
endinterface

// File: rtl/temp_monitor_mc.sv
// Multi-channel signed-BCD temperature monitor: 3-stage pipeline (BCD decode, delta/classify, BCD encode).
// Optional alarm-clear hysteresis is enabled by defining TEMP_MONITOR_HYST_EN.
module temp_monitor_mc #(
    parameter int CHANNELS   = 4,
    parameter int DIGITS     = 3,
    parameter int HIGH_LIMIT = 100,
    parameter int LOW_LIMIT  = -20,
    parameter int HYST       = 5
) (
    input logic              clk,
    input logic              rst,
    temp_monitor_mc_if.slave bus
);
    function automatic int pow10(input int unsigned n);
        int r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int          MAXV = pow10(DIGITS) - 1;
    localparam int          VW   = $clog2(MAXV + 1) + 1;
    localparam int          DW   = $clog2(2 * MAXV + 1) + 1;
    localparam int          CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int          OW   = (DIGITS + 1) * 4;
    localparam int unsigned NCH  = CHANNELS;
    localparam int unsigned NDIG = DIGITS;
`ifdef TEMP_MONITOR_HYST_EN
    localparam int HystEff = HYST;
`else
    localparam int HystEff = HYST * 0;
`endif

    typedef enum logic [2:0] {
        ST_STEADY     = 3'd0,
        ST_RISING     = 3'd1,
        ST_FALLING    = 3'd2,
        ST_ALARM_HIGH = 3'd3,
        ST_ALARM_LOW  = 3'd4
    } state_e;

    // S1: decode and validate
    logic [VW-1:0]        mag_d;
    logic [3:0]           nib_d;
    logic                 bcd_ok_d;
    logic                 ch_ok_d;
    logic signed [VW-1:0] val_d;

    always_comb begin
        mag_d    = '0;
        nib_d    = '0;
        bcd_ok_d = 1'b1;
        for (int unsigned i = NDIG; i > 0; i--) begin
            nib_d = bus.in_bcd[4*(i-1) +: 4];
            if (nib_d > 4'd9) bcd_ok_d = 1'b0;
            mag_d = mag_d * VW'(10) + VW'(nib_d);
        end
        ch_ok_d = 32'(bus.in_ch) < NCH;
        val_d   = $signed(mag_d);
        if (bus.in_sign && (mag_d != '0)) val_d = -val_d;
    end

    logic                 s1_valid_q, s1_ok_q, s1_mode_q;
    logic [CH_W-1:0]      s1_ch_q;
    logic signed [VW-1:0] s1_val_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_ch_q    <= '0;
            s1_val_q   <= '0;
        end else begin
            s1_valid_q <= bus.en & bus.in_valid;
            s1_ok_q    <= bcd_ok_d & ch_ok_d;
            s1_mode_q  <= bus.mode;
            s1_ch_q    <= bus.in_ch;
            s1_val_q   <= val_d;
        end
    end

    // S2: channel memory is both read and committed here, so back-to-back samples see fresh values
    logic signed [VW-1:0] hist_q [CHANNELS];
    logic signed [VW-1:0] base_q [CHANNELS];
    logic [CHANNELS-1:0]  hist_vld_q, base_vld_q, hi_q, lo_q;

    logic signed [VW-1:0] ref_d;
    logic                 ref_ok_d;
    logic signed [DW-1:0] delta_d;
    logic                 hi_d, lo_d;
    state_e               state_d;

    always_comb begin
        ref_d    = hist_q[s1_ch_q];
        ref_ok_d = hist_vld_q[s1_ch_q];
        if (s1_mode_q) begin
            ref_d    = base_q[s1_ch_q];
            ref_ok_d = base_vld_q[s1_ch_q];
        end
        delta_d = ref_ok_d ? (DW'(s1_val_q) - DW'(ref_d)) : '0;

        hi_d = hi_q[s1_ch_q];
        if (s1_val_q >= HIGH_LIMIT) hi_d = 1'b1;
        else if (s1_val_q < HIGH_LIMIT - HystEff) hi_d = 1'b0;
        lo_d = lo_q[s1_ch_q];
        if (s1_val_q <= LOW_LIMIT) lo_d = 1'b1;
        else if (s1_val_q > LOW_LIMIT + HystEff) lo_d = 1'b0;

        if (hi_d)                 state_d = ST_ALARM_HIGH;
        else if (lo_d)            state_d = ST_ALARM_LOW;
        else if (delta_d > 0)     state_d = ST_RISING;
        else if (delta_d < 0)     state_d = ST_FALLING;
        else                      state_d = ST_STEADY;
    end

    logic                 s2_valid_q, s2_err_q, s2_alm_q;
    logic [CH_W-1:0]      s2_ch_q;
    logic signed [DW-1:0] s2_delta_q;
    state_e               s2_state_q;
    logic                 commit_d;

    assign commit_d = s1_valid_q & s1_ok_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                base_q[i] <= '0;
            end
            hist_vld_q <= '0;
            base_vld_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_alm_q   <= 1'b0;
            s2_ch_q    <= '0;
            s2_delta_q <= '0;
            s2_state_q <= ST_STEADY;
        end else begin
            if (commit_d) begin
                hist_q[s1_ch_q]     <= s1_val_q;
                hist_vld_q[s1_ch_q] <= 1'b1;
                hi_q[s1_ch_q]       <= hi_d;
                lo_q[s1_ch_q]       <= lo_d;
                // Any mode-0 sample drops every baseline, so the first mode-1 sample after it recaptures
                if (!s1_mode_q) begin
                    base_vld_q <= '0;
                end else if (!base_vld_q[s1_ch_q]) begin
                    base_vld_q[s1_ch_q] <= 1'b1;
                    base_q[s1_ch_q]     <= s1_val_q;
                end
            end
            s2_valid_q <= s1_valid_q;
            s2_err_q   <= s1_valid_q & ~s1_ok_q;
            s2_alm_q   <= hi_d | lo_d;
            s2_ch_q    <= s1_valid_q ? s1_ch_q : '0;
            s2_delta_q <= commit_d ? delta_d : '0;
            s2_state_q <= commit_d ? state_d : ST_STEADY;
        end
    end

    // S3: encode magnitude to BCD and register outputs
    logic [DW-1:0] rem_d;
    logic [OW-1:0] bcd_d;

    always_comb begin
        bcd_d = '0;
        rem_d = s2_delta_q[DW-1] ? DW'(-s2_delta_q) : DW'(s2_delta_q);
        for (int unsigned i = 0; i < NDIG + 1; i++) begin
            bcd_d[4*i +: 4] = 4'(rem_d % DW'(10));
            rem_d           = rem_d / DW'(10);
        end
    end

    logic                out_valid_q, out_err_q, out_sign_q;
    logic [CH_W-1:0]     out_ch_q;
    logic [OW-1:0]       out_bcd_q;
    state_e              out_state_q;
    logic [CHANNELS-1:0] alarm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_sign_q  <= 1'b0;
            out_ch_q    <= '0;
            out_bcd_q   <= '0;
            out_state_q <= ST_STEADY;
            alarm_q     <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_err_q   <= s2_err_q;
            out_sign_q  <= s2_delta_q[DW-1];
            out_ch_q    <= s2_ch_q;
            out_bcd_q   <= bcd_d;
            out_state_q <= s2_state_q;
            if (s2_valid_q && !s2_err_q) alarm_q[s2_ch_q] <= s2_alm_q;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_err        = out_err_q;
    assign bus.out_delta_sign = out_sign_q;
    assign bus.out_ch         = out_ch_q;
    assign bus.out_delta_bcd  = out_bcd_q;
    assign bus.out_state      = out_state_q;
    assign bus.alarm          = alarm_q;
endmodule

// File: tb/tb_temp_monitor_mc.sv
// Self-checking bench for temp_monitor_mc: integer reference model with a timed expectation
// queue, plus hand-computed literal expectations on selected results.
module tb_temp_monitor_mc;
    localparam int CH = 4;
    localparam int DG = 3;
    localparam int OW = (DG + 1) * 4;
`ifdef TEMP_MONITOR_HYST_EN
    localparam int HY = 5;
`else
    localparam int HY = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    temp_monitor_mc_if #(.CHANNELS(CH), .DIGITS(DG)) bus ();

    temp_monitor_mc #(
        .CHANNELS(CH), .DIGITS(DG), .HIGH_LIMIT(100), .LOW_LIMIT(-20), .HYST(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            ch;
        logic [OW-1:0] bcd;
        logic          sgn;
        int            st;
        logic          err;
        logic [CH-1:0] alm;
        int            lbcd;
        int            lsgn;
        int            lst;
        int            lalm;
    } exp_t;

    exp_t          q[$];
    exp_t          ce;
    logic [CH-1:0] exp_alarm = '0;
    logic [CH-1:0] m_alarm   = '0;
    int            m_hist[CH];
    int            m_base[CH];
    bit            m_hv[CH];
    bit            m_bv[CH];
    bit            m_hi[CH];
    bit            m_lo[CH];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < CH; k++) begin
            m_hist[k] = 0; m_base[k] = 0;
            m_hv[k] = 0; m_bv[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
        end
        m_alarm = '0;
    endtask

    // Reference: integer temperatures, delta, flags and state straight from the rules
    task automatic model(input int ch, input logic [11:0] bcd, input bit sgn, input bit md,
                         output exp_t e);
        int mag;
        bit ok;
        int v, r, d, m, nb;
        mag = 0;
        ok  = (ch < CH);
        for (int i = DG - 1; i >= 0; i--) begin
            nb = int'(bcd[4*i +: 4]);
            if (nb > 9) ok = 0;
            mag = mag * 10 + nb;
        end
        e.ch = ch; e.bcd = '0; e.sgn = 0; e.st = 0; e.err = !ok; e.alm = m_alarm;
        e.lbcd = -1; e.lsgn = -1; e.lst = -1; e.lalm = -1; e.due = 0;
        if (!ok) return;
        v = sgn ? -mag : mag;
        if (!md) begin
            for (int k = 0; k < CH; k++) m_bv[k] = 0;
            r = m_hv[ch] ? m_hist[ch] : v;
        end else begin
            if (!m_bv[ch]) begin
                m_base[ch] = v;
                m_bv[ch]   = 1;
            end
            r = m_base[ch];
        end
        d = v - r;
        m_hist[ch] = v;
        m_hv[ch]   = 1;
        if (v >= 100) m_hi[ch] = 1;
        else if (v < 100 - HY) m_hi[ch] = 0;
        if (v <= -20) m_lo[ch] = 1;
        else if (v > -20 + HY) m_lo[ch] = 0;
        m_alarm[ch] = m_hi[ch] | m_lo[ch];
        e.alm = m_alarm;
        e.st  = m_hi[ch] ? 3 : m_lo[ch] ? 4 : (d > 0) ? 1 : (d < 0) ? 2 : 0;
        e.sgn = (d < 0);
        m = (d < 0) ? -d : d;
        for (int i = 0; i <= DG; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endtask

    task automatic send(input int ch, input logic [11:0] bcd, input bit sgn, input bit md,
                        input int lbcd = -1, input int lsgn = -1, input int lst = -1,
                        input int lalm = -1);
        exp_t e;
        @(posedge clk); #1;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'(ch);
        bus.in_bcd   = bcd;
        bus.in_sign  = sgn;
        bus.mode     = md;
        model(ch, bcd, sgn, md, e);
        e.due  = cyc + 3;
        e.lbcd = lbcd; e.lsgn = lsgn; e.lst = lst; e.lalm = lalm;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.en       = 1'b1;
            bus.in_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            ce = q.pop_front();
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_ch", 32'(bus.out_ch), 32'(ce.ch));
            chk("out_err", 32'(bus.out_err), 32'(ce.err));
            chk("out_delta_bcd", 32'(bus.out_delta_bcd), 32'(ce.bcd));
            chk("out_delta_sign", 32'(bus.out_delta_sign), 32'(ce.sgn));
            chk("out_state", 32'(bus.out_state), 32'(ce.st));
            exp_alarm = ce.alm;
            if (ce.lbcd >= 0) chk("lit_delta_bcd", 32'(bus.out_delta_bcd), 32'(ce.lbcd));
            if (ce.lsgn >= 0) chk("lit_delta_sign", 32'(bus.out_delta_sign), 32'(ce.lsgn));
            if (ce.lst >= 0)  chk("lit_state", 32'(bus.out_state), 32'(ce.lst));
            if (ce.lalm >= 0) chk("lit_alarm_bit", 32'(bus.alarm[ce.ch]), 32'(ce.lalm));
        end else begin
            chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
        end
        chk("alarm", 32'(bus.alarm), 32'(exp_alarm));
    end

    initial begin
        bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b0;
        bus.in_ch = '0; bus.in_bcd = '0; bus.in_sign = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // basic deltas on ch0
        send(0, 12'h025, 0, 0, 16'h0000, 0, 0, 0);
        idle(4);
        send(0, 12'h030, 0, 0, 16'h0005, 0, 1, 0);
        idle(4);

        // back-to-back on ch1
        send(1, 12'h010, 0, 0, 16'h0000, 0, 0);
        send(1, 12'h050, 0, 0, 16'h0040, 0, 1);
        send(1, 12'h010, 1, 0, 16'h0060, 1, 2);
        idle(4);

        // full-scale swing and negative zero on ch2, one cycle apart
        send(2, 12'h999, 0, 0, 16'h0000, 0, 3, 1);
        idle(1);
        send(2, 12'h999, 1, 0, 16'h1998, 1, 4, 1);
        idle(1);
        send(2, 12'h000, 1, 0, 16'h0999, 0, 1, 0);
        idle(4);

        // high alarm clear thresholds on ch3
        send(3, 12'h100, 0, 0, 16'h0000, 0, 3, 1);
`ifdef TEMP_MONITOR_HYST_EN
        send(3, 12'h097, 0, 0, 16'h0003, 1, 3, 1);
        send(3, 12'h094, 0, 0, 16'h0003, 1, 2, 0);
`else
        send(3, 12'h097, 0, 0, 16'h0003, 1, 2, 0);
        send(3, 12'h094, 0, 0, 16'h0003, 1, 2, 0);
`endif
        idle(4);

        // baseline mode on ch0, back to mode 0, then recapture
        send(0, 12'h020, 0, 1, 16'h0000, 0, 0);
        send(0, 12'h035, 0, 1, 16'h0015, 0, 1);
        send(0, 12'h012, 0, 1, 16'h0008, 1, 2);
        idle(2);
        send(0, 12'h015, 0, 0, 16'h0003, 0, 1);
        send(0, 12'h040, 0, 1, 16'h0000, 0, 0);
        idle(4);

        // invalid BCD, then en=0 sample; neither may touch ch0 history
        send(0, 12'h1A3, 0, 0, 16'h0000, 0, 0);
        @(posedge clk); #1;
        bus.en = 1'b0; bus.in_valid = 1'b1; bus.in_ch = 2'd0;
        bus.in_bcd = 12'h050; bus.in_sign = 1'b0; bus.mode = 1'b0;
        idle(4);
        send(0, 12'h045, 0, 0, 16'h0005, 0, 1);
        idle(4);

        // committed alarm on ch1, then reset with two samples in flight
        send(1, 12'h120, 0, 0, 16'h0130, 0, 3, 1);
        idle(4);
        send(0, 12'h150, 0, 0);
        send(3, 12'h005, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        q.delete();
        exp_alarm = '0;
        model_clear();
        idle(2);
        rst = 1'b0;
        idle(2);
        send(0, 12'h025, 0, 0, 16'h0000, 0, 0, 0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/temp_monitor_mc.md
Name: temp_monitor_mc

Overview:
Multi-channel successor to the single-channel BCD temperature monitor. Accepts time-multiplexed signed BCD samples tagged with a channel number. Per sample it computes a signed BCD delta, either against that channel's previous sample or against a captured per-channel baseline, and classifies the channel as steady, rising, falling or in high/low alarm. Sits between the sensor/BCD front end and the display/alarm logic.

Parameters:
CHANNELS, 4, number of monitored channels (1..16)
DIGITS, 3, BCD magnitude digits per input sample (1..4)
HIGH_LIMIT, 100, signed integer; value >= HIGH_LIMIT raises the high alarm
LOW_LIMIT, -20, signed integer; value <= LOW_LIMIT raises the low alarm
HYST, 5, alarm-clear hysteresis magnitude (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  sample enable; when 0, in_valid is ignored
mode  in  1  0 = delta vs previous sample; 1 = delta vs baseline
in_valid  in  1  sample strobe, one sample per cycle maximum
in_ch  in  CH_W=max(1,$clog2(CHANNELS))  channel tag
in_bcd  in  DIGITS*4  BCD magnitude, most significant digit on the top nibble
in_sign  in  1  1 = negative
out_valid  out  1  one-cycle result strobe
out_ch  out  CH_W  channel of the result
out_delta_bcd  out  (DIGITS+1)*4  BCD magnitude of the delta
out_delta_sign  out  1  1 = negative delta
out_state  out  3  0 STEADY, 1 RISING, 2 FALLING, 3 ALARM_HIGH, 4 ALARM_LOW
out_err  out  1  sample rejected (invalid BCD or in_ch >= CHANNELS)
alarm  out  CHANNELS  level output; bit n = channel n is in high or low alarm

Behaviour:
- Reset: all outputs 0; pipeline flushed; every channel marked "no history, no baseline"; alarm flags cleared. Reset asserted mid-pipeline drops in-flight samples with no out_valid.
- Pipeline, full throughput, fixed latency 3: a sample accepted in cycle N (en & in_valid) gives out_valid in cycle N+3.
  - S1: BCD-to-binary conversion and validity check.
  - S2: history/baseline lookup, subtract, classify, state update.
  - S3: binary-to-BCD conversion and output registers.
- A sample is valid only if every nibble is <= 9 and in_ch < CHANNELS. An invalid sample gives out_valid=1, out_err=1, delta 0, out_state 0, and leaves channel memory and alarm unchanged.
- Negative zero (sign=1, magnitude 0) is treated as +0. A zero delta always reports out_delta_sign=0.
- Mode 0: delta = value − previous value of the same channel. The first sample after reset gives delta 0.
- Mode 1: delta = value − baseline. The baseline is captured from the first valid sample of each channel after mode goes 0→1 or after reset with mode=1; that sample reports delta 0. A 1→0 transition discards all baselines.
- mode is sampled with each sample in S1. The previous-value store is updated for every valid sample in both modes.
- Delta range is ±2*(10^DIGITS−1), hence DIGITS+1 output digits. Internal arithmetic is signed binary, wide enough for that range, with no saturation.
- State priority:
  - ALARM_HIGH if the channel's high flag is set.
  - else ALARM_LOW if the low flag is set.
  - else RISING if delta > 0, FALLING if delta < 0, STEADY if delta = 0.
- Alarm flags: high flag set when value >= HIGH_LIMIT, cleared when value < HIGH_LIMIT. Low flag set when value <= LOW_LIMIT, cleared when value > LOW_LIMIT. alarm[n] = high | low, updated in the same cycle as out_valid.
- Hazard: back-to-back or one-apart samples on the same channel see the preceding sample's committed value, baseline and flags (forwarding from S2/S3). No bubbles are inserted.
- en=0: no new samples; in-flight samples complete normally.

Optional Feature:
TEMP_MONITOR_HYST_EN
- Defined: the high flag clears only when value < HIGH_LIMIT−HYST; the low flag clears only when value > LOW_LIMIT+HYST. Set conditions are unchanged.
- Undefined: clear thresholds are exactly as in Behaviour; the HYST parameter is unused.

Test Plan:
1. Reset, mode 0, ch0 +025 then ch0 +030 → out_valid 3 cycles after each in_valid; +0000 STEADY, then +0005 RISING.
2. Consecutive cycles on ch1: +010, +050, −010 → +0000 STEADY, +0040 RISING, −0060 FALLING (forwarding check).
3. ch2 +999 then −999 → second result delta −1998, ALARM_LOW, alarm[2]=1; then ch2 −000 → +0999 RISING, alarm[2]=0.
4. ch3 +100, +097, +094 → ALARM_HIGH alarm[3]=1; then with HYST_EN: ALARM_HIGH, FALLING alarm[3]=0; without HYST_EN: FALLING alarm=0, FALLING.
5. mode=1, ch0 +020, +035, +012 → +0000, +0015 RISING, −0008 FALLING; mode→0 then ch0 +015 → +0003 RISING.
6. in_bcd 0x1A3 → out_err=1, delta 0, ch memory unchanged; en=0 with in_valid=1 → no out_valid; rst pulse while 2 samples in flight → no out_valid, alarm=0.
